// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared widths, redirect kinds, LRLI opcode and FSM state codes
//            for the instruction-fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int c_PC_W    = 8;
  localparam int c_INSTR_W = 16;

  localparam logic [1:0] c_REDIR_JUMP = 2'd0;
  localparam logic [1:0] c_REDIR_CALL = 2'd1;
  localparam logic [1:0] c_REDIR_RET  = 2'd2;

  localparam logic [6:0] c_LRLI_OPC = 7'b1000010;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t c_ST_BOOT  = 2'd0;
  localparam fetch_state_t c_ST_RUN   = 2'd1;
  localparam fetch_state_t c_ST_EXT   = 2'd2;
  localparam fetch_state_t c_ST_FLUSH = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fetch_ras.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ras
// Purpose  : Circular return-address LIFO; a push when full overwrites the
//            oldest entry, a pop when empty returns zero. err pulses on either.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic         err
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]       r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_ptr;
  logic [c_PTR_W:0]   r_count;
  logic [c_PTR_W-1:0] w_top;

  assign w_top    = r_ptr - c_PTR_W'(1);
  assign full     = (r_count == (c_PTR_W + 1)'(DEPTH));
  assign empty    = (r_count == '0);
  assign pop_data = empty ? '0 : r_mem[w_top];
  assign err      = (push && full) || (pop && !push && empty);

  // When full, r_ptr already points at the oldest slot, so the write wraps onto it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + c_PTR_W'(1);
      if (!full) begin
        r_count <= r_count + (c_PTR_W + 1)'(1);
      end
    end else if (pop && !empty) begin
      r_ptr   <= w_top;
      r_count <= r_count - (c_PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_ptr] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Owns the PC, fetches ROM words into a valid/ready holding stage,
//            tags LRLI literal words and applies execute redirects.
//            Return-address stack enabled by defining FETCH_RAS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W      = c_PC_W,
  parameter int INSTR_W   = c_INSTR_W,
  parameter int RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_ext,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redir_valid,
  input  logic [1:0]         redir_kind,
  input  logic [PC_W-1:0]    redir_pc,
  input  logic [PC_W-1:0]    link_pc,
  output logic               ras_err
);

  fetch_state_t       r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_ipc;
  logic               r_ext;
  logic               r_valid;

  logic               w_redir;
  logic               w_ld;
  logic               w_lrli;
  logic [PC_W-1:0]    w_target;

  assign w_redir = redir_valid && (r_state != c_ST_BOOT);
  assign w_ld    = (r_state != c_ST_BOOT) && (!r_valid || instr_ready) && !redir_valid;
  assign w_lrli  = (rom_data[INSTR_W-1 -: 7] == c_LRLI_OPC);

`ifdef FETCH_RAS_EN
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_ras_top;
  logic            w_ras_full;
  logic            w_ras_empty;
  logic            w_ras_err;
  logic            r_ras_err;
  logic            w_unused_ras;

  assign w_push = w_redir && (redir_kind == c_REDIR_CALL);
  assign w_pop  = w_redir && (redir_kind == c_REDIR_RET);

  fetch_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (link_pc),
    .pop_data  (w_ras_top),
    .full      (w_ras_full),
    .empty     (w_ras_empty),
    .err       (w_ras_err)
  );

  assign w_target     = w_pop ? w_ras_top : redir_pc;
  assign w_unused_ras = ^{w_ras_full, w_ras_empty};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ras_err <= 1'b0;
    end else if (w_ras_err) begin
      r_ras_err <= 1'b1;
    end
  end

  assign ras_err = r_ras_err;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = ^{redir_kind, link_pc, (RAS_DEPTH > 0)};
  assign w_target     = redir_pc;
  assign ras_err      = 1'b0;
`endif

  // Pending-ext is encoded as the EXT state; the literal word itself is never
  // inspected for the LRLI opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_BOOT;
      r_pc    <= '0;
      r_instr <= '0;
      r_ipc   <= '0;
      r_ext   <= 1'b0;
      r_valid <= 1'b0;
    end else if (r_state == c_ST_BOOT) begin
      r_state <= c_ST_RUN;
    end else if (w_redir) begin
      r_pc    <= w_target;
      r_valid <= 1'b0;
      r_state <= c_ST_FLUSH;
    end else if (w_ld) begin
      r_instr <= rom_data;
      r_ipc   <= r_pc;
      r_valid <= 1'b1;
      r_pc    <= r_pc + PC_W'(1);
      r_ext   <= (r_state == c_ST_EXT);
      r_state <= ((r_state != c_ST_EXT) && w_lrli) ? c_ST_EXT : c_ST_RUN;
    end
  end

  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_ipc;
  assign instr_ext   = r_ext;
  assign instr_valid = r_valid;

endmodule
`default_nettype wire
